// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with valid/ready handshake and a registered result.
// Define ALU_MULDIV_EN to build the iterative RV32M multiply/divide unit.
module alu_md #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  state_t state, state_nxt;

  logic          accept, fast, done;
  logic [W-1:0]  base_res, fast_res;
  logic [SW-1:0] shamt;

  assign accept = in_valid & in_ready;
  assign shamt  = SrcB[SW-1:0];

  always_comb begin
    base_res = '0;
    case (Operation[3:0])
      4'd0:        base_res = SrcA & SrcB;
      4'd1:        base_res = SrcA | SrcB;
      4'd2:        base_res = SrcA + SrcB;
      4'd3:        base_res = SrcA ^ SrcB;
      4'd4:        base_res = SrcA << shamt;
      4'd5:        base_res = SrcA >> shamt;
      4'd6:        base_res = SrcA - SrcB;
      4'd7:        base_res = $signed(SrcA) >>> shamt;
      4'd8:        base_res = {{(W-1){1'b0}}, SrcA == SrcB};
      4'd9, 4'd12: base_res = {{(W-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      4'd10:       base_res = {{(W-1){1'b0}}, $signed(SrcA) >= $signed(SrcB)};
      4'd11:       base_res = {{(W-1){1'b0}}, SrcA != SrcB};
      4'd13:       base_res = {{(W-1){1'b0}}, SrcA < SrcB};
      default:     base_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef struct packed {
    logic [2:0] op;
    logic       neg;
  } mctx_t;

  localparam logic [W-1:0]  MIN     = {1'b1, {(W-1){1'b0}}};
  localparam logic [SW-1:0] ITER_LD = SW'(W-1);

  mctx_t           ctx;
  logic [2*W-1:0]  acc, acc_nxt, prod;
  logic [W-1:0]    opnd, mag_a, mag_b, dval, it_res;
  logic [W:0]      sum, shifted, diff;
  logic [SW-1:0]   iter;
  logic            is_div, sgn_a, sgn_b, neg_a, neg_b, b_zero, ovf;

  // MUL is run as signed x signed; its low half matches the unsigned product.
  assign is_div = Operation[2];
  assign sgn_a  = is_div ? !Operation[0] : (Operation[1:0] != 2'b11);
  assign sgn_b  = is_div ? !Operation[0] : !Operation[1];
  assign neg_a  = sgn_a & SrcA[W-1];
  assign neg_b  = sgn_b & SrcB[W-1];
  assign mag_a  = neg_a ? -SrcA : SrcA;
  assign mag_b  = neg_b ? -SrcB : SrcB;
  assign b_zero = (SrcB == '0);
  assign ovf    = !Operation[0] & (SrcA == MIN) & (SrcB == '1);
  assign fast   = !Operation[4] | Operation[3] | (is_div & (b_zero | ovf));
  assign done   = (state == BUSY) & (iter == '0);

  always_comb begin
    fast_res = base_res;
    if (Operation[4]) begin
      fast_res = '0;
      if (!Operation[3] && is_div) begin
        if (b_zero)   fast_res = Operation[1] ? SrcA : '1;
        else if (ovf) fast_res = Operation[1] ? '0 : MIN;
      end
    end
  end

  // acc holds {hi, lo}: product accumulator for multiply, {remainder, quotient} for divide.
  always_comb begin
    sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = {acc[2*W-1:W], acc[W-1]};
    diff    = shifted - {1'b0, opnd};
    if (ctx.op[2])
      acc_nxt = diff[W] ? {shifted[W-1:0], acc[W-2:0], 1'b0}
                        : {diff[W-1:0], acc[W-2:0], 1'b1};
    else
      acc_nxt = {sum, acc[W-1:1]};
    prod = ctx.neg ? -acc_nxt : acc_nxt;
    dval = ctx.op[1] ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];
    if (ctx.op[2]) it_res = ctx.neg ? -dval : dval;
    else           it_res = (ctx.op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iter <= '0;
      ctx  <= '0;
      acc  <= '0;
      opnd <= '0;
    end else if (accept && !fast) begin
      iter <= ITER_LD;
      ctx  <= '{op: Operation[2:0], neg: (is_div & Operation[1]) ? neg_a : (neg_a ^ neg_b)};
      acc  <= {{W{1'b0}}, is_div ? mag_a : mag_b};
      opnd <= is_div ? mag_b : mag_a;
    end else if (state == BUSY) begin
      acc  <= acc_nxt;
      iter <= iter - 1'b1;
    end
  end
`else
  assign fast     = 1'b1;
  assign done     = 1'b0;
  assign fast_res = Operation[4] ? '0 : base_res;
`endif

  always_ff @(posedge clk) begin
    if (reset)               ALUResult <= '0;
    else if (accept && fast) ALUResult <= fast_res;
`ifdef ALU_MULDIV_EN
    else if (done && !flush) ALUResult <= it_res;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || flush) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? HOLD : BUSY;
`ifdef ALU_MULDIV_EN
      BUSY:    if (done) state_nxt = HOLD;
`endif
      HOLD: begin
        if (accept)         state_nxt = fast ? HOLD : BUSY;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !reset && !flush && ((state == IDLE) || ((state == HOLD) && out_ready));
    out_valid = (state == HOLD);
  end
endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md (DATA_WIDTH=32); expectations follow
// ALU_MULDIV_EN so the same bench covers both builds.
module tb_alu_md;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] SrcA, SrcB, ALUResult;
  logic [4:0]  Operation;
  int          checks = 0;
  int          errors = 0;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, exp;
  } vec_t;

  always #5 clk = ~clk;

  alu_md #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
  endtask

  task automatic release_in();
    in_valid  = 1'b0;
    SrcA      = $urandom;
    SrcB      = $urandom;
    Operation = 5'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    release_in();
    tick(); tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++;
    if (ALUResult !== 32'h0) begin errors++; $display("FAIL reset result: got %h want 0", ALUResult); end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_sub();
    drive(5'd2, 32'h7FFF_FFFF, 32'h1);
    tick();
    checks++;
    if ({out_valid, ALUResult} !== {1'b1, 32'h8000_0000})
      begin errors++; $display("FAIL add: got %b/%h want 1/80000000", out_valid, ALUResult); end
    drive(5'd6, 32'd5, 32'd7);
    tick();
    checks++;
    if ({out_valid, ALUResult} !== {1'b1, 32'hFFFF_FFFE})
      begin errors++; $display("FAIL b2b sub: got %b/%h want 1/fffffffe", out_valid, ALUResult); end
    release_in();
    tick();
  endtask

  task automatic run_vectors(input string tag, input vec_t v[$]);
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b);
      tick();
      checks++;
      if ({out_valid, ALUResult} !== {1'b1, v[i].exp}) begin
        errors++;
        $display("FAIL %s op=%0d a=%h b=%h: got %b/%h want 1/%h",
                 tag, v[i].op, v[i].a, v[i].b, out_valid, ALUResult, v[i].exp);
      end
    end
    release_in();
    tick();
  endtask

  task automatic test_base_ops();
    vec_t v[$];
    v.push_back('{5'd0,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F});
    v.push_back('{5'd1,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF});
    v.push_back('{5'd3,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0});
    v.push_back('{5'd2,  32'hFFFF_FFFF, 32'h2,         32'h1});
    v.push_back('{5'd4,  32'h1,         32'h21,        32'h2});
    v.push_back('{5'd4,  32'h1,         32'h1F,        32'h8000_0000});
    v.push_back('{5'd5,  32'h8000_0000, 32'h4,         32'h0800_0000});
    v.push_back('{5'd6,  32'h0,         32'h1,         32'hFFFF_FFFF});
    v.push_back('{5'd7,  32'h8000_0000, 32'h24,        32'hF800_0000});
    v.push_back('{5'd7,  32'h4000_0000, 32'h2,         32'h1000_0000});
    v.push_back('{5'd8,  32'd5,         32'd5,         32'h1});
    v.push_back('{5'd8,  32'd5,         32'd6,         32'h0});
    v.push_back('{5'd9,  32'hFFFF_FFFF, 32'h1,         32'h1});
    v.push_back('{5'd9,  32'h1,         32'hFFFF_FFFF, 32'h0});
    v.push_back('{5'd10, 32'hFFFF_FFFF, 32'h1,         32'h0});
    v.push_back('{5'd10, 32'd7,         32'd7,         32'h1});
    v.push_back('{5'd11, 32'd5,         32'd6,         32'h1});
    v.push_back('{5'd12, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1});
    v.push_back('{5'd13, 32'hFFFF_FFFF, 32'h1,         32'h0});
    v.push_back('{5'd13, 32'h1,         32'hFFFF_FFFF, 32'h1});
    v.push_back('{5'd14, 32'd3,         32'd4,         32'h0});
    v.push_back('{5'd15, 32'hFFFF_FFFF, 32'h1,         32'h0});
    run_vectors("base", v);
  endtask

  task automatic test_muldiv_fast();
    vec_t v[$];
    v.push_back('{5'd21, 32'd5,         32'd0,         MD ? 32'hFFFF_FFFF : 32'h0});
    v.push_back('{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
    v.push_back('{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, MD ? 32'h8000_0000 : 32'h0});
    v.push_back('{5'd23, 32'd9,         32'd0,         MD ? 32'd9 : 32'h0});
    v.push_back('{5'd24, 32'd9,         32'd3,         32'h0});
    v.push_back('{5'd31, 32'hFFFF_FFFF, 32'd3,         32'h0});
    run_vectors("mdfast", v);
  endtask

  task automatic run_iter(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    logic       bad;
    logic [1:0] first;
    drive(op, a, b);
    tick();
    release_in();
    bad = 1'b0; first = 2'b00;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick();
      if (!bad && (in_ready !== 1'b0 || out_valid !== 1'b0)) begin
        bad = 1'b1; first = {in_ready, out_valid};
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL busy op=%0d: got in_ready/out_valid=%b want 00", op, first);
    end
    tick();
    checks++;
    if ({out_valid, ALUResult} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL iter op=%0d a=%h b=%h: got %b/%h want 1/%h", op, a, b, out_valid, ALUResult, exp);
    end
  endtask

  task automatic test_muldiv_iter();
`ifdef ALU_MULDIV_EN
    run_iter(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    run_iter(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_iter(5'd16, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_iter(5'd18, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
    run_iter(5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_iter(5'd22, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_iter(5'd21, 32'd100,       32'd7,         32'd14);
    run_iter(5'd23, 32'd100,       32'd7,         32'd2);
    release_in();
    tick();
`else
    vec_t v[$];
    v.push_back('{5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0});
    v.push_back('{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0});
    v.push_back('{5'd16, 32'd7,         32'd3,         32'h0});
    v.push_back('{5'd20, 32'hFFFF_FFF9, 32'd2,         32'h0});
    run_vectors("mdoff", v);
`endif
  endtask

  task automatic test_backpressure();
    logic bad;
    out_ready = 1'b0;
    drive(5'd2, 32'd3, 32'd4);
    tick();
    checks++;
    if ({out_valid, ALUResult} !== {1'b1, 32'd7})
      begin errors++; $display("FAIL bp first: got %b/%h want 1/7", out_valid, ALUResult); end
    drive(5'd3, 32'hA, 32'h5);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid !== 1'b1 || ALUResult !== 32'd7 || in_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad || out_valid !== 1'b1 || ALUResult !== 32'd7 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp hold: got %b/%h/%b want 1/7/0", out_valid, ALUResult, in_ready);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    tick();
    checks++;
    if ({out_valid, ALUResult} !== {1'b1, 32'hF})
      begin errors++; $display("FAIL bp next: got %b/%h want 1/f", out_valid, ALUResult); end
    release_in();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp drain: got %b want 0", out_valid); end
  endtask

  // Abort (flush or reset) mid-DIV when M ops exist, otherwise while a result is held.
  task automatic test_abort(input bit use_reset);
    logic [31:0] keep;
`ifdef ALU_MULDIV_EN
    out_ready = 1'b1;
    drive(5'd20, 32'hFFFF_FFF9, 32'd2);
    tick();
    release_in();
    repeat (9) tick();
    keep = ALUResult;
`else
    out_ready = 1'b0;
    drive(5'd2, 32'd10, 32'd20);
    tick();
    keep = 32'd30;
`endif
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    drive(5'd2, 32'd100, 32'd100);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL abort%0d in_ready: got %b want 0", use_reset, in_ready); end
    tick();
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    release_in();
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      begin errors++; $display("FAIL abort%0d ctl: got ov/ir=%b%b want 01", use_reset, out_valid, in_ready); end
    checks++;
    if (ALUResult !== (use_reset ? 32'h0 : keep))
      begin errors++; $display("FAIL abort%0d result: got %h want %h", use_reset, ALUResult, use_reset ? 32'h0 : keep); end
    drive(5'd2, 32'd1, 32'd1);
    tick();
    checks++;
    if ({out_valid, ALUResult} !== {1'b1, 32'd2})
      begin errors++; $display("FAIL abort%0d add: got %b/%h want 1/2", use_reset, out_valid, ALUResult); end
    release_in();
    repeat (40) tick();
    checks++;
    if ({out_valid, ALUResult} !== {1'b0, 32'd2})
      begin errors++; $display("FAIL abort%0d stale: got %b/%h want 0/2", use_reset, out_valid, ALUResult); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_sub();
    test_base_ops();
    test_muldiv_fast();
    test_muldiv_iter();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_md.md
# alu_md

Parametrised, multi-cycle successor to the pipeline's execute-stage ALU. It adds a valid/ready handshake, a registered result, corrected signed compare and shift semantics, and iterative RV32M multiply/divide. It sits in EX and stalls the pipeline through `in_ready` while a multi-cycle operation is in flight.

## Interface
- `DATA_WIDTH`, 32: operand and result width; must be even and ≥ 8.
- `OPCODE_LENGTH`, 5: operation code width; fixed encoding below.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset` in, 1: synchronous, active-high.
- `flush` in, 1: abort the in-flight operation and drop any held result.
- `in_valid` in, 1: `SrcA`/`SrcB`/`Operation` valid this cycle.
- `in_ready` out, 1: block accepts input this cycle.
- `SrcA` in, DATA_WIDTH: operand A.
- `SrcB` in, DATA_WIDTH: operand B.
- `Operation` in, OPCODE_LENGTH: operation select.
- `out_valid` out, 1: `ALUResult` holds a result.
- `out_ready` in, 1: consumer takes the result this cycle.
- `ALUResult` out, DATA_WIDTH: registered result.

## Operation
- Base ops, `Operation[4]=0`:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 6 SUB (all modulo 2^DATA_WIDTH).
  - 4 SLL, 5 SRL: shift amount is `SrcB[$clog2(DATA_WIDTH)-1:0]`.
  - 7 SRA: arithmetic shift, SrcA treated as signed.
  - 8 EQ, 9 LT signed, 10 GE signed, 11 NE, 12 SLT signed, 13 SLTU unsigned: result 1 or 0, zero-extended.
  - 14, 15: result 0.
- M ops, `Operation[4]=1`:
  - 16 MUL (low half), 17 MULH (signed × signed), 18 MULHSU (signed × unsigned), 19 MULHU (unsigned × unsigned); high-half ops return bits [2W-1:W].
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU; 24–31 return 0.
- Multiply: shift-add on magnitudes, one bit per cycle; sign is fixed up in the final cycle.
- Divide: restoring division on magnitudes, one bit per cycle.
  - Quotient sign is the XOR of operand signs; remainder takes the dividend's sign.
- Division special cases complete on the fast path (latency 1):
  - Divide by zero: quotient all-ones; remainder = SrcA.
  - Signed overflow (MIN / −1): quotient MIN; remainder 0.
- FSM states: IDLE, BUSY, HOLD.
  - IDLE → HOLD on accepting a base op or fast-path M op.
  - IDLE → BUSY on accepting an iterative M op; `iter` counter loads DATA_WIDTH−1.
  - BUSY decrements `iter`; at 0 the result is written and the FSM enters HOLD.
  - HOLD → IDLE on `out_ready` with no new accept.
  - HOLD with `out_ready` and an accept goes directly to the next state (back-to-back).
- `in_ready = (state==IDLE) | (state==HOLD & out_ready)`, all gated by `!reset & !flush`.
- `flush`: any state → IDLE next cycle; `out_valid` deasserts; an input presented in the same cycle is not accepted. `flush` and `reset` have equal effect on control state.

## Timing
- Reset values: state IDLE, `out_valid`=0, `ALUResult`=0, `in_ready`=0 during reset and 1 in the first cycle after.
- Base op / fast path: accepted at edge N → `out_valid` and result visible after edge N (latency 1).
- Iterative M op: accepted at edge N → `out_valid` after edge N+DATA_WIDTH (latency DATA_WIDTH; BUSY for DATA_WIDTH−1 cycles, plus the final write edge).
- `ALUResult` is stable while `out_valid & !out_ready`; it changes only on accept-and-write or reset.
- Throughput: one base op per cycle when `out_ready` is held high.
- Operands are captured at accept; later changes on `SrcA`/`SrcB` are ignored.

## Configuration
- `ALU_MULDIV_EN` defined: M ops implemented as above.
- `ALU_MULDIV_EN` undefined:
  - Opcodes 16–31 return 0 with latency 1.
  - BUSY state and iteration datapath are not synthesised.
  - Base-op behaviour and timing are unchanged.

## Test plan
- Reset then ADD 0x7FFFFFFF + 1, `out_ready`=1 → one cycle later `out_valid`=1, result 0x80000000; back-to-back SUB 5−7 → 0xFFFFFFFE on the next cycle.
- SRA 0x80000000 by SrcB=0x24 (amount 4) → 0xF8000000; LT signed (−1, 1) → 1; SLTU (0xFFFFFFFF, 1) → 0.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0 after 32 cycles, `in_ready`=0 throughout BUSY; MULHU same operands → 0xFFFFFFFE.
- DIV −7 / 2 → −3 and REM → −1 (latency 32); DIVU 5 / 0 → 0xFFFFFFFF and REM 0x80000000 / 0xFFFFFFFF → 0, both at latency 1.
- `out_ready`=0 for 5 cycles after a result → `ALUResult` and `out_valid` held and `in_ready`=0; on release a new op is accepted the same cycle.
- `flush` and `reset` each asserted mid-DIV (cycle 10 of BUSY) → next cycle IDLE, `out_valid`=0; the following ADD 1 + 1 → 2 with latency 1.
